// File: rtl/stack_master.sv
// stack_master: initiator-side driver for a LIFO stack with a fixed read latency.
// Turns a valid/ready write stream and a request/valid read stream into
// push/pop/data_in commands. It tracks committed depth so the stack never
// overflows or underflows, supports a drain-to-empty flush, and halts on any
// error the stack reports.
module stack_master #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STK_RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic              err_clr,
  output logic              busy,
  output logic [4:0]        depth,
  output logic              full,
  output logic              empty,
  output logic              err_flag,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_error
);

  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      depth_nxt;
  logic                  push_nxt;
  logic                  pop_nxt;
  logic                  dlv_nxt;
  logic [DATA_W-1:0]     data_in_nxt;
  logic                  err_nxt;

  // pop_dlv travels with stk_pop: set for read pops, clear for flush pops.
  logic                  pop_dlv;
  // fly tracks every issued pop through the stack latency; dlv only those
  // whose data must be returned to the reader.
  logic [STK_RD_LAT-1:0] fly;
  logic [STK_RD_LAT-1:0] dlv;
  logic                  in_flight;
  logic                  wr_acc;
  logic                  rd_acc;

  // Handshake readies: only in READY, flush blocks both, a read beats a write.
  assign rd_ready  = (state == ST_READY) && !flush && !empty;
  assign wr_ready  = (state == ST_READY) && !flush && !full && !(rd_req && !empty);
  assign rd_acc    = rd_req && rd_ready;
  assign wr_acc    = wr_valid && wr_ready;

  // Returned data and status derived from registered pipeline state.
  assign in_flight = stk_pop || (|fly);
  assign busy      = (state != ST_READY) || in_flight;
  assign rd_valid  = dlv[STK_RD_LAT-1];
  assign rd_data   = rd_valid ? stk_data_out : '0;

  // Next-state, depth and stack-command decode.
  always_comb begin
    state_nxt   = state;
    depth_nxt   = depth;
    push_nxt    = 1'b0;
    pop_nxt     = 1'b0;
    dlv_nxt     = 1'b0;
    data_in_nxt = stk_data_in;
    err_nxt     = err_flag || stk_error;

    case (state)
      ST_READY: begin
        if (flush) begin
          state_nxt = ST_FLUSH;
        end else if (rd_acc) begin
          depth_nxt = depth - CNT_W'(1);
          pop_nxt   = 1'b1;
          dlv_nxt   = 1'b1;
        end else if (wr_acc) begin
          depth_nxt   = depth + CNT_W'(1);
          push_nxt    = 1'b1;
          data_in_nxt = wr_data;
        end
      end
      ST_FLUSH: begin
        if (depth != CNT_W'(0)) begin
          // No new pop is issued in the cycle an error is reported.
          if (!stk_error) begin
            depth_nxt = depth - CNT_W'(1);
            pop_nxt   = 1'b1;
          end
        end else if (!in_flight) begin
          state_nxt = ST_READY;
        end
      end
      ST_HALT: begin
        if (err_clr && !stk_error && !in_flight) begin
          state_nxt = ST_READY;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_READY;
      end
    endcase

    if (stk_error) begin
      state_nxt = ST_HALT;
    end
  end

  // State, depth, stack command and pop-tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_READY;
      depth       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      err_flag    <= 1'b0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_data_in <= '0;
      pop_dlv     <= 1'b0;
      fly         <= '0;
      dlv         <= '0;
    end else begin
      state       <= state_nxt;
      depth       <= depth_nxt;
      full        <= (depth_nxt == CNT_W'(DEPTH));
      empty       <= (depth_nxt == CNT_W'(0));
      err_flag    <= err_nxt;
      stk_push    <= push_nxt;
      stk_pop     <= pop_nxt;
      stk_data_in <= data_in_nxt;
      pop_dlv     <= dlv_nxt;
      fly         <= (fly << 1) | STK_RD_LAT'(stk_pop);
      dlv         <= (dlv << 1) | STK_RD_LAT'(stk_pop && pop_dlv);
    end
  end

endmodule

// File: tb/tb_stack_master.sv
// tb_stack_master: directed, table-driven bench for stack_master with a
// behavioural 16-entry LIFO (two-cycle read latency) attached.
module tb_stack_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_req;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       flush;
  logic       err_clr;
  logic       busy;
  logic [4:0] depth;
  logic       full;
  logic       empty;
  logic       err_flag;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic       stk_error;
  logic       force_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_master #(.DEPTH(16), .DATA_W(8), .STK_RD_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .flush(flush), .err_clr(err_clr), .busy(busy), .depth(depth),
    .full(full), .empty(empty), .err_flag(err_flag),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_error(stk_error)
  );

  // Behavioural stack: data appears two cycles after the pop cycle.
  logic [7:0] mem [16];
  int         sp;
  logic [7:0] q1;
  logic [7:0] q2;

  assign stk_data_out = q2;
  assign stk_error    = force_err || (stk_push && sp == 16) || (stk_pop && sp == 0) ||
                        (stk_push && stk_pop);

  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
      q1 <= 8'h00;
      q2 <= 8'h00;
    end else begin
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_data_in;
        sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
        q1 <= mem[sp-1];
        sp <= sp - 1;
      end
      q2 <= q1;
    end
  end

  // Event counters sampled mid-cycle.
  int push_cnt = 0;
  int pop_cnt  = 0;
  int rv_cnt   = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (stk_push)  push_cnt++;
    if (stk_pop)   pop_cnt++;
    if (rd_valid)  rv_cnt++;
    if (stk_error) err_cnt++;
  end

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_wr_ready;
    logic       e_rd_ready;
    logic       e_push;
    logic [7:0] e_sdi;
    logic       e_pop;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic [4:0] e_depth;
    logic       e_busy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr,
                              input logic ewr, input logic erd, input logic epush,
                              input logic [7:0] esdi, input logic epop, input logic erv,
                              input logic [7:0] erdata, input logic [4:0] edep,
                              input logic ebusy);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_wr_ready = ewr; v.e_rd_ready = erd; v.e_push = epush; v.e_sdi = esdi;
    v.e_pop = epop; v.e_rv = erv; v.e_rdata = erdata; v.e_depth = edep; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
    flush = 1'b0; err_clr = 1'b0; force_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(k);
      step();
    end
    wr_valid = 1'b0;
  endtask

  int base_push;
  int base_pop;
  int base_rv;
  int base_err;
  int waited;

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Test 1 and 4: push 3 / pop 3, then depth 4 with simultaneous rd and wr.
    tbl[0]  = mk(1, 8'h11, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 5'd0, 0);
    tbl[1]  = mk(1, 8'h22, 0, 1, 1, 1, 8'h11, 0, 0, 8'h00, 5'd1, 0);
    tbl[2]  = mk(1, 8'h33, 0, 1, 1, 1, 8'h22, 0, 0, 8'h00, 5'd2, 0);
    tbl[3]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 0, 0, 8'h00, 5'd3, 0);
    tbl[4]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0, 8'h00, 5'd2, 1);
    tbl[5]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0, 8'h00, 5'd1, 1);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 1, 8'h33, 5'd0, 1);
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 8'h22, 5'd0, 1);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 8'h11, 5'd0, 1);
    tbl[9]  = mk(1, 8'hA0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 5'd0, 0);
    tbl[10] = mk(1, 8'hA1, 0, 1, 1, 1, 8'hA0, 0, 0, 8'h00, 5'd1, 0);
    tbl[11] = mk(1, 8'hA2, 0, 1, 1, 1, 8'hA1, 0, 0, 8'h00, 5'd2, 0);
    tbl[12] = mk(1, 8'hA3, 0, 1, 1, 1, 8'hA2, 0, 0, 8'h00, 5'd3, 0);
    tbl[13] = mk(1, 8'hA4, 1, 0, 1, 1, 8'hA3, 0, 0, 8'h00, 5'd4, 0);
    tbl[14] = mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 8'h00, 5'd3, 1);
    tbl[15] = mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 5'd3, 1);
    tbl[16] = mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 8'hA3, 5'd3, 1);
    tbl[17] = mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 5'd3, 0);

    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_wr_ready", 0, 32'(wr_ready), 32'd1);
    chk("rst_rd_ready", 0, 32'(rd_ready), 32'd0);
    chk("rst_empty",    0, 32'(empty),    32'd1);
    chk("rst_full",     0, 32'(full),     32'd0);
    chk("rst_depth",    0, 32'(depth),    32'd0);
    chk("rst_busy",     0, 32'(busy),     32'd0);
    chk("rst_err_flag", 0, 32'(err_flag), 32'd0);
    chk("rst_stk_cmd",  0, 32'({stk_push, stk_pop, rd_valid}), 32'd0);
    chk("rst_rd_data",  0, 32'(rd_data),  32'd0);
    step();

    // Table-driven cycle vectors.
    for (int i = 0; i < NVEC; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].wd;
      rd_req   = tbl[i].rr;
      @(negedge clk);
      chk("v_wr_ready", i, 32'(wr_ready), 32'(tbl[i].e_wr_ready));
      chk("v_rd_ready", i, 32'(rd_ready), 32'(tbl[i].e_rd_ready));
      chk("v_stk_push", i, 32'(stk_push), 32'(tbl[i].e_push));
      if (tbl[i].e_push)
        chk("v_stk_data_in", i, 32'(stk_data_in), 32'(tbl[i].e_sdi));
      chk("v_stk_pop",  i, 32'(stk_pop),  32'(tbl[i].e_pop));
      chk("v_rd_valid", i, 32'(rd_valid), 32'(tbl[i].e_rv));
      chk("v_rd_data",  i, 32'(rd_data),  32'(tbl[i].e_rdata));
      chk("v_depth",    i, 32'(depth),    32'(tbl[i].e_depth));
      chk("v_busy",     i, 32'(busy),     32'(tbl[i].e_busy));
      step();
    end
    idle_inputs();

    // Test 2: fill to 16, then a held 17th write must stall.
    do_reset();
    base_push = push_cnt;
    base_err  = err_cnt;
    wr_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      wr_data = 8'(i);
      if (i == 18) begin
        @(negedge clk);
        chk("full_wr_ready", 2, 32'(wr_ready), 32'd0);
        step();
      end else begin
        step();
      end
    end
    wr_valid = 1'b0;
    step();
    @(negedge clk);
    chk("full_push_cnt", 2, 32'(push_cnt - base_push), 32'd16);
    chk("full_flag",     2, 32'(full),     32'd1);
    chk("full_depth",    2, 32'(depth),    32'd16);
    chk("full_stack_sp", 2, 32'(sp),       32'd16);
    chk("full_no_err",   2, 32'(err_cnt - base_err), 32'd0);
    step();

    // Test 3: read requests while empty are never accepted.
    do_reset();
    base_pop = pop_cnt;
    base_rv  = rv_cnt;
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_rd_ready", i, 32'(rd_ready), 32'd0);
      step();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("empty_pop_cnt", 3, 32'(pop_cnt - base_pop), 32'd0);
    chk("empty_rv_cnt",  3, 32'(rv_cnt - base_rv),   32'd0);

    // Test 5: flush with depth 5 drains silently.
    do_reset();
    push_n(5, 8'h50);
    step();
    base_pop = pop_cnt;
    base_rv  = rv_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",     5, 32'(busy),     32'd1);
    chk("flush_wr_ready", 5, 32'(wr_ready), 32'd0);
    chk("flush_rd_ready", 5, 32'(rd_ready), 32'd0);
    waited = 0;
    while (busy && waited < 40) begin
      step();
      @(negedge clk);
      waited++;
    end
    chk("flush_timeout", 5, 32'(waited < 40), 32'd1);
    chk("flush_pop_cnt", 5, 32'(pop_cnt - base_pop), 32'd5);
    chk("flush_rv_cnt",  5, 32'(rv_cnt - base_rv),   32'd0);
    chk("flush_depth",   5, 32'(depth),    32'd0);
    chk("flush_empty",   5, 32'(empty),    32'd1);
    chk("flush_ready",   5, 32'(wr_ready), 32'd1);
    chk("flush_sp",      5, 32'(sp),       32'd0);
    step();

    // Test 6: stack error halts; same-cycle clear loses; clear recovers.
    do_reset();
    push_n(2, 8'h60);
    step();
    base_pop = pop_cnt;
    force_err = 1'b1;
    step();
    force_err = 1'b0;
    @(negedge clk);
    chk("halt_err_flag", 6, 32'(err_flag), 32'd1);
    chk("halt_readies",  6, 32'({wr_ready, rd_ready}), 32'd0);
    chk("halt_busy",     6, 32'(busy),     32'd1);
    chk("halt_depth",    6, 32'(depth),    32'd2);
    step();
    force_err = 1'b1;
    err_clr   = 1'b1;
    step();
    force_err = 1'b0;
    err_clr   = 1'b0;
    rd_req    = 1'b1;
    @(negedge clk);
    chk("halt_set_wins", 6, 32'(err_flag), 32'd1);
    chk("halt_rd_ready", 6, 32'(rd_ready), 32'd0);
    step();
    rd_req  = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_flag", 6, 32'(err_flag), 32'd0);
    chk("clr_wr_ready", 6, 32'(wr_ready), 32'd1);
    chk("clr_rd_ready", 6, 32'(rd_ready), 32'd1);
    chk("clr_busy",     6, 32'(busy),     32'd0);
    chk("clr_depth",    6, 32'(depth),    32'd2);
    chk("halt_pop_cnt", 6, 32'(pop_cnt - base_pop), 32'd0);
    step();

    // Test 7: reset right after a read accept drops the pending data.
    do_reset();
    push_n(3, 8'h70);
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    reset  = 1'b1;
    base_rv = rv_cnt;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    chk("rst_mid_rv_cnt", 7, 32'(rv_cnt - base_rv), 32'd0);
    chk("rst_mid_depth",  7, 32'(depth), 32'd0);
    chk("rst_mid_empty",  7, 32'(empty), 32'd1);
    chk("rst_mid_busy",   7, 32'(busy),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
